// File: rtl/morphle_wb_loader_if.sv
// Wishbone classic slave bus bundle for the Morphle yblock configuration loader.
// Ports: stb/cyc/we/sel/adr/dat_i from the master; ack/dat_o from the slave.
// Single-beat accesses only; the slave returns one registered ack per access.
interface morphle_wb_loader_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/morphle_wb_loader.sv
// Wishbone register front-end and row-at-a-time configuration sequencer for one yblock.
// Latency: ack one cycle after stb&cyc; a row load occupies CONF_SETUP+CONF_PULSE+CONF_HOLD cycles.
// Backpressure: a CBIT write is wait-stated (no ack) while a load is in flight or cell_reset=1.
//
// Ports: wb_clk_i/wb_rst_i (async, active-low), wb (Wishbone slave modport),
//        cell_reset/confclk/cbitin to the yblock, cbitout/uout from it, uin into its top edge.
// Option: MORPHLE_CAPTURE_EN adds 2-flop synchronisers on uout/cbitout and a sticky
//        "uout changed" flag in STATUS bit2; without it those reads sample the raw inputs.
// Register map (adr[4:2]): 0 CTRL, 1 STATUS, 2 CBIT, 3 UIN, 4 UOUT, 5 CBITOUT; others read 0.
module morphle_wb_loader #(
    parameter int BLOCKWIDTH  = 16,
    parameter int BLOCKHEIGHT = 16,
    parameter int CONF_SETUP  = 2,
    parameter int CONF_PULSE  = 2,
    parameter int CONF_HOLD   = 2
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    morphle_wb_loader_if.slave      wb,
    output logic                    cell_reset,
    output logic                    confclk,
    output logic [BLOCKWIDTH-1:0]   cbitin,
    input  logic [BLOCKWIDTH-1:0]   cbitout,
    output logic [2*BLOCKWIDTH-1:0] uin,
    input  logic [2*BLOCKWIDTH-1:0] uout
);
    localparam int UW = 2 * BLOCKWIDTH;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_CBIT    = 3'd2;
    localparam logic [2:0] REG_UIN     = 3'd3;
    localparam logic [2:0] REG_UOUT    = 3'd4;
    localparam logic [2:0] REG_CBITOUT = 3'd5;

    // Phase counters load length-1 and count down to zero.
    localparam logic [3:0] SETUP_LD = 4'(CONF_SETUP - 1);
    localparam logic [3:0] PULSE_LD = 4'(CONF_PULSE - 1);
    localparam logic [3:0] HOLD_LD  = 4'(CONF_HOLD - 1);
    localparam logic [7:0] ROW_LAST = 8'(BLOCKHEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  row;
    logic        done;

    logic        req;
    logic        accept;
    logic        cbit_wr;
    logic        busy;
    logic        ctrl_wr;
    logic        uin_wr;
    logic        status_rd;
    logic [2:0]  reg_sel;
    logic [31:0] uin_ext;
    logic [31:0] rdata;
    logic        uout_chg;
    logic [UW-1:0]         uout_rd;
    logic [BLOCKWIDTH-1:0] cbitout_rd;

    // Only adr[4:2] is decoded.
    logic unused_adr;
    assign unused_adr = &{1'b0, wb.wbs_adr_i[31:5], wb.wbs_adr_i[1:0]};

    always_comb begin
        reg_sel = wb.wbs_adr_i[4:2];
        busy    = (state != ST_IDLE);
        // Masking with ack keeps a held strobe from producing back-to-back acks.
        req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~wb.wbs_ack_o;
        cbit_wr = req & wb.wbs_we_i & (reg_sel == REG_CBIT);
        // Row loads wait for an idle sequencer and for the cells to be out of reset.
        accept    = req & ~(cbit_wr & (busy | cell_reset));
        ctrl_wr   = accept & wb.wbs_we_i & (reg_sel == REG_CTRL);
        uin_wr    = accept & wb.wbs_we_i & (reg_sel == REG_UIN);
        status_rd = accept & ~wb.wbs_we_i & (reg_sel == REG_STATUS);

        uin_ext = 32'(uin);
        for (int b = 0; b < 4; b++) begin
            if (wb.wbs_sel_i[b]) begin
                uin_ext[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
            end
        end

        rdata = 32'd0;
        case (reg_sel)
            REG_CTRL:    rdata = {31'd0, cell_reset};
            REG_STATUS:  rdata = {16'd0, row, 5'd0, uout_chg, done, busy};
            REG_UIN:     rdata = 32'(uin);
            REG_UOUT:    rdata = 32'(uout_rd);
            REG_CBITOUT: rdata = 32'(cbitout_rd);
            default:     rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= 32'd0;
            cell_reset   <= 1'b1;
            confclk      <= 1'b0;
            cbitin       <= '0;
            uin          <= '0;
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            row          <= 8'd0;
            done         <= 1'b0;
        end else begin
            wb.wbs_ack_o <= accept;
            if (accept) begin
                wb.wbs_dat_o <= wb.wbs_we_i ? 32'd0 : rdata;
            end

            // Read-to-clear first so a same-cycle wrap below keeps done set.
            if (status_rd) begin
                done <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cbit_wr && accept) begin
                        cbitin <= wb.wbs_dat_i[BLOCKWIDTH-1:0];
                        state  <= ST_SETUP;
                        cnt    <= SETUP_LD;
                    end
                end
                ST_SETUP: begin
                    if (cnt == 4'd0) begin
                        state   <= ST_PULSE;
                        confclk <= 1'b1;
                        cnt     <= PULSE_LD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == 4'd0) begin
                        state   <= ST_HOLD;
                        confclk <= 1'b0;
                        cnt     <= HOLD_LD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == 4'd0) begin
                        state <= ST_IDLE;
                        if (row == ROW_LAST) begin
                            row  <= 8'd0;
                            done <= 1'b1;
                        end else begin
                            row <= row + 8'd1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Freezing the cells aborts the load and overrides any row update above.
            if (ctrl_wr) begin
                cell_reset <= wb.wbs_dat_i[0];
                if (wb.wbs_dat_i[0]) begin
                    state   <= ST_IDLE;
                    confclk <= 1'b0;
                    cnt     <= 4'd0;
                    row     <= 8'd0;
                    done    <= 1'b0;
                end
            end

            if (uin_wr) begin
                uin <= uin_ext[UW-1:0];
            end
        end
    end

`ifdef MORPHLE_CAPTURE_EN
    logic [UW-1:0]         uout_s1, uout_s2, uout_prev;
    logic [BLOCKWIDTH-1:0] cbitout_s1, cbitout_s2;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            uout_s1    <= '0;
            uout_s2    <= '0;
            uout_prev  <= '0;
            cbitout_s1 <= '0;
            cbitout_s2 <= '0;
            uout_chg   <= 1'b0;
        end else begin
            uout_s1    <= uout;
            uout_s2    <= uout_s1;
            uout_prev  <= uout_s2;
            cbitout_s1 <= cbitout;
            cbitout_s2 <= cbitout_s1;
            // A change seen in the same cycle as a STATUS read is kept.
            if (uout_s2 != uout_prev) begin
                uout_chg <= 1'b1;
            end else if (status_rd) begin
                uout_chg <= 1'b0;
            end
        end
    end

    assign uout_rd    = uout_s2;
    assign cbitout_rd = cbitout_s2;
`else
    assign uout_rd    = uout;
    assign cbitout_rd = cbitout;
    assign uout_chg   = 1'b0;
`endif

endmodule

// File: tb/tb_morphle_wb_loader.sv
// Directed bench for morphle_wb_loader: register map, row sequencing, wait states,
// abort, wrap/done, byte-lane UIN writes and readback paths.
// Expected values are hand-computed constants for BLOCKWIDTH=16, 2-2-2 timing.
module tb_morphle_wb_loader;
    localparam int BW = 16;

    localparam logic [31:0] A_CTRL    = 32'h00;
    localparam logic [31:0] A_STATUS  = 32'h04;
    localparam logic [31:0] A_CBIT    = 32'h08;
    localparam logic [31:0] A_UIN     = 32'h0C;
    localparam logic [31:0] A_UOUT    = 32'h10;
    localparam logic [31:0] A_CBITOUT = 32'h14;
    localparam logic [31:0] A_UNMAP   = 32'h18;

    logic            clk;
    logic            rst_n;
    logic            cell_reset;
    logic            confclk;
    logic [BW-1:0]   cbitin;
    logic [BW-1:0]   cbitout;
    logic [2*BW-1:0] uin;
    logic [2*BW-1:0] uout;

    int checks   = 0;
    int failures = 0;
    int rises    = 0;

    morphle_wb_loader_if bus ();

    morphle_wb_loader #(
        .BLOCKWIDTH (BW),
        .BLOCKHEIGHT(16),
        .CONF_SETUP (2),
        .CONF_PULSE (2),
        .CONF_HOLD  (2)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .wb        (bus.slave),
        .cell_reset(cell_reset),
        .confclk   (confclk),
        .cbitin    (cbitin),
        .cbitout   (cbitout),
        .uin       (uin),
        .uout      (uout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge confclk) rises++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raised ack.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int budget,
                           output logic [31:0] rdat, output logic acked, output int waited);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        acked  = 1'b0;
        waited = 0;
        rdat   = 32'd0;
        while (!acked && waited < budget) begin
            @(posedge clk);
            #1;
            waited++;
            if (bus.wbs_ack_o) begin
                acked = 1'b1;
                rdat  = bus.wbs_dat_o;
            end
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr_sel(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
        logic [31:0] rd;
        logic        ok;
        int          w;
        wb_xfer(1'b1, adr, dat, sel, 20, rd, ok, w);
        check({tag, "_ack"}, 32'(ok), 32'd1);
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat);
        wr_sel(tag, adr, dat, 4'hF);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] mask,
                          input logic [31:0] exp);
        logic [31:0] rdat;
        logic        ok;
        int          w;
        wb_xfer(1'b0, adr, 32'd0, 4'hF, 20, rdat, ok, w);
        check({tag, "_ack"}, 32'(ok), 32'd1);
        check(tag, rdat & mask, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdat;
        logic        ok;
        int          w;
        int          r0;
        int          first_hi;
        int          hi_cnt;
        logic        seen;

        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'd0;
        bus.wbs_dat_i = 32'd0;
        cbitout = '0;
        uout    = '0;
        rst_n   = 1'b0;
        #23;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_cell_reset", 32'(cell_reset), 32'd1);
        check("rst_confclk", 32'(confclk), 32'd0);
        check("rst_uin", 32'(uin), 32'd0);
        check("rst_cbitin", 32'(cbitin), 32'd0);
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        rd_chk("rst_status", A_STATUS, 32'hFFFF_FFFF, 32'h0);
        rd_chk("rst_ctrl", A_CTRL, 32'hFFFF_FFFF, 32'h1);

        // Single row load: 2 setup, 2 pulse, 2 hold
        wr("ctrl0", A_CTRL, 32'h0);
        check("ctrl0_cell_reset", 32'(cell_reset), 32'd0);
        r0 = rises;
        wr("cbit_a5", A_CBIT, 32'h0000_A5A5);
        check("a5_cbitin", 32'(cbitin), 32'h0000_A5A5);
        first_hi = -1;
        hi_cnt   = 0;
        for (int i = 1; i <= 10; i++) begin
            cycles(1);
            if (confclk) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
        end
        check("a5_clk_start", 32'(first_hi), 32'd2);
        check("a5_clk_width", 32'(hi_cnt), 32'd2);
        check("a5_rises", 32'(rises - r0), 32'd1);
        rd_chk("a5_status", A_STATUS, 32'hFFFF_FFFF, 32'h0000_0100);
        check("a5_cbitin_idle", 32'(cbitin), 32'h0000_A5A5);

        // Busy visible in STATUS during a load
        wr("cbit_busy", A_CBIT, 32'h0000_0003);
        rd_chk("busy_status", A_STATUS, 32'hFFFF_FFFF, 32'h0000_0101);
        cycles(8);

        // Back-to-back rows: second ack waits for the first load to finish
        wr("ctrl_rst1", A_CTRL, 32'h1);
        wr("ctrl_rst0", A_CTRL, 32'h0);
        r0 = rises;
        wr("b2b_1", A_CBIT, 32'h0000_0001);
        wb_xfer(1'b1, A_CBIT, 32'h0000_0002, 4'hF, 20, rdat, ok, w);
        check("b2b_2_ack", 32'(ok), 32'd1);
        check("b2b_2_wait", 32'(w), 32'd7);
        check("b2b_2_cbitin", 32'(cbitin), 32'h0000_0002);
        cycles(8);
        check("b2b_rises", 32'(rises - r0), 32'd2);
        rd_chk("b2b_status", A_STATUS, 32'hFFFF_FFFF, 32'h0000_0200);

        // Full frame: row wraps to 0 and done is read-to-clear
        wr("wrap_rst1", A_CTRL, 32'h1);
        wr("wrap_rst0", A_CTRL, 32'h0);
        for (int i = 0; i < 16; i++) begin
            wr("wrap_row", A_CBIT, 32'h0000_0100 + 32'(i));
        end
        cycles(8);
        rd_chk("wrap_status", A_STATUS, 32'hFFFF_FFFF, 32'h0000_0002);
        rd_chk("wrap_status2", A_STATUS, 32'hFFFF_FFFF, 32'h0000_0000);
        check("wrap_cbitin", 32'(cbitin), 32'h0000_010F);

        // Abort during PULSE
        wr("ab_row", A_CBIT, 32'h0000_0011);
        cycles(8);
        wr("ab_cbit", A_CBIT, 32'h0000_00FF);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycles(1);
            if (confclk) seen = 1'b1;
        end
        check("ab_pulse_seen", 32'(seen), 32'd1);
        wr("ab_ctrl1", A_CTRL, 32'h1);
        check("ab_confclk", 32'(confclk), 32'd0);
        check("ab_cell_reset", 32'(cell_reset), 32'd1);
        rd_chk("ab_status", A_STATUS, 32'hFFFF_FFFF, 32'h0000_0000);

        // CBIT write while frozen is wait-stated and loads nothing
        r0 = rises;
        wb_xfer(1'b1, A_CBIT, 32'h0000_1234, 4'hF, 10, rdat, ok, w);
        check("frozen_no_ack", 32'(ok), 32'd0);
        check("frozen_cbitin", 32'(cbitin), 32'h0000_00FF);
        check("frozen_rises", 32'(rises - r0), 32'd0);
        cycles(1);
        wr("ab_ctrl0", A_CTRL, 32'h0);

        // UIN with byte lanes
        wr("uin_full", A_UIN, 32'h1234_5678);
        check("uin_full", 32'(uin), 32'h1234_5678);
        wr_sel("uin_lanes", A_UIN, 32'hAABB_CCDD, 4'b0101);
        check("uin_lanes", 32'(uin), 32'h12BB_56DD);
        rd_chk("uin_rd", A_UIN, 32'hFFFF_FFFF, 32'h12BB_56DD);

        // Readback paths and unmapped address
        uout    = 32'hCAFE_F00D;
        cbitout = 16'h5A3C;
        cycles(3);
        rd_chk("uout_rd", A_UOUT, 32'hFFFF_FFFF, 32'hCAFE_F00D);
        rd_chk("cbitout_rd", A_CBITOUT, 32'hFFFF_FFFF, 32'h0000_5A3C);
        rd_chk("cbit_wo_rd", A_CBIT, 32'hFFFF_FFFF, 32'h0);
        wr("unmap_wr", A_UNMAP, 32'hFFFF_FFFF);
        rd_chk("unmap_rd", A_UNMAP, 32'hFFFF_FFFF, 32'h0);
        check("unmap_uin", 32'(uin), 32'h12BB_56DD);

`ifdef MORPHLE_CAPTURE_EN
        uout = 32'h0;
        cycles(4);
        rd_chk("cap_clear", A_STATUS, 32'h0, 32'h0);
        uout = 32'h0000_1234;
        cycles(3);
        rd_chk("cap_uout", A_UOUT, 32'hFFFF_FFFF, 32'h0000_1234);
        rd_chk("cap_chg1", A_STATUS, 32'h4, 32'h4);
        rd_chk("cap_chg2", A_STATUS, 32'h4, 32'h0);
`else
        uout = 32'h0000_1234;
        rd_chk("raw_uout", A_UOUT, 32'hFFFF_FFFF, 32'h0000_1234);
        rd_chk("raw_chg", A_STATUS, 32'h4, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
